// File: rtl/audio_mix_stage_pkg.sv
// Shared types, constants and saturating arithmetic for the tone/mic mixing stage.
package audio_mix_stage_pkg;

   localparam int SAMPLE_W = 5;
   localparam int AUDIO_W  = 32;

   localparam logic [SAMPLE_W-1:0] TONE_SILENCE = 5'd16;
   localparam logic [AUDIO_W-1:0]  SAT_POS      = 32'h7FFF_FFFF;
   localparam logic [AUDIO_W-1:0]  SAT_NEG      = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_HOLDOFF
   } state_t;

   // Signed add clamped to the 32-bit range instead of wrapping.
   function automatic logic [AUDIO_W-1:0] sat_add32(input logic [AUDIO_W-1:0] a,
                                                    input logic [AUDIO_W-1:0] b);
      logic [AUDIO_W:0] s;
      s = {a[AUDIO_W-1], a} + {b[AUDIO_W-1], b};
      if (s[AUDIO_W] != s[AUDIO_W-1])
         return s[AUDIO_W] ? SAT_NEG : SAT_POS;
      return s[AUDIO_W-1:0];
   endfunction

endpackage

// File: rtl/audio_mix_stage_if.sv
// Tone sample stream plus Audio_Controller frame handshake; slave is the mix stage.
interface audio_mix_stage_if;
   import audio_mix_stage_pkg::*;

   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample_in;
   logic                sample_ready;

   logic                audio_in_available;
   logic                audio_out_allowed;
   logic [AUDIO_W-1:0]  left_channel_audio_in;
   logic [AUDIO_W-1:0]  right_channel_audio_in;
   logic                read_audio_in;
   logic                write_audio_out;
   logic [AUDIO_W-1:0]  left_channel_audio_out;
   logic [AUDIO_W-1:0]  right_channel_audio_out;

   modport master (
      output sample_valid, sample_in,
      input  sample_ready,
      output audio_in_available, audio_out_allowed,
      output left_channel_audio_in, right_channel_audio_in,
      input  read_audio_in, write_audio_out,
      input  left_channel_audio_out, right_channel_audio_out
   );

   modport slave (
      input  sample_valid, sample_in,
      output sample_ready,
      input  audio_in_available, audio_out_allowed,
      input  left_channel_audio_in, right_channel_audio_in,
      output read_audio_in, write_audio_out,
      output left_channel_audio_out, right_channel_audio_out
   );

endinterface

// File: rtl/audio_mix_stage_tone_fifo.sv
// Synchronous FIFO; head visible combinationally, one-cycle write-to-read.
// Caller qualifies push/pop: push only when !full (or popping), pop only when !empty.
module tone_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;

endmodule

// File: rtl/audio_mix_stage.sv
// Buffers ROM tone samples, scales and mixes them with mic audio, one codec frame per decision.
// Decision cycle -> strobes and registered data 1 cycle later; sample_ready low when the FIFO is full.
module audio_mix_stage
   import audio_mix_stage_pkg::*;
#(
   parameter int FIFO_DEPTH        = 4,
   parameter int FRAMES_PER_SAMPLE = 8,
   parameter int BASE_SHIFT        = 19
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   audio_mix_stage_if.slave   bus,
   input  logic [2:0]         volume,
   input  logic               mute,
   input  logic               mic_enable,
   output logic [2:0]         fifo_level,
   output logic [7:0]         underflow_cnt,
   output logic               overflow
);

   localparam int FC_W = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;
   localparam int LV_W = $clog2(FIFO_DEPTH) + 1;

   state_t              state, state_nxt;
   logic [FC_W-1:0]     frame_cnt;
   logic [SAMPLE_W-1:0] held_tone;
   logic [AUDIO_W-1:0]  out_l, out_r;

   logic                decide, pop_req, pop_ok, push_ok;
   logic                fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0] fifo_head, tone_sel;
   logic [LV_W-1:0]     fifo_lvl;
   logic [AUDIO_W-1:0]  tone_ext, tone32, mic_l, mic_r, mix_l, mix_r;
   logic [4:0]          shamt;

   assign decide  = (state == ST_IDLE) && bus.audio_in_available && bus.audio_out_allowed;
   assign pop_req = decide && (frame_cnt == '0);
   assign pop_ok  = pop_req && !fifo_empty;
   // A pop frees the slot a simultaneous push needs, so a full FIFO still accepts it.
   assign push_ok = bus.sample_valid && (!fifo_full || pop_ok);

   tone_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_tone_fifo (
      .clk   (CLOCK_50),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop_ok),
      .din   (bus.sample_in),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_lvl)
   );

   // Offset binary -> two's complement is just an MSB flip, then sign-extend.
   assign tone_sel = pop_ok ? fifo_head : held_tone;
   assign tone_ext = {{(AUDIO_W-SAMPLE_W+1){~tone_sel[SAMPLE_W-1]}}, tone_sel[SAMPLE_W-2:0]};
   assign shamt    = 5'(BASE_SHIFT) + 5'(volume);
   assign tone32   = mute ? '0 : (tone_ext << shamt);
   assign mic_l    = mic_enable ? bus.left_channel_audio_in  : '0;
   assign mic_r    = mic_enable ? bus.right_channel_audio_in : '0;
   assign mix_l    = sat_add32(mic_l, tone32);
   assign mix_r    = sat_add32(mic_r, tone32);

   always_ff @(posedge CLOCK_50) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt           = state;
      bus.read_audio_in   = 1'b0;
      bus.write_audio_out = 1'b0;
      case (state)
         ST_IDLE:    if (decide) state_nxt = ST_WRITE;
         ST_WRITE: begin
            bus.read_audio_in   = 1'b1;
            bus.write_audio_out = 1'b1;
            state_nxt           = ST_HOLDOFF;
         end
         ST_HOLDOFF: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         frame_cnt     <= '0;
         held_tone     <= TONE_SILENCE;
         out_l         <= '0;
         out_r         <= '0;
         underflow_cnt <= '0;
         overflow      <= 1'b0;
      end else begin
         if (decide) begin
            out_l     <= mix_l;
            out_r     <= mix_r;
            frame_cnt <= (frame_cnt == FC_W'(FRAMES_PER_SAMPLE - 1)) ? '0 : frame_cnt + FC_W'(1);
         end
         if (pop_ok)
            held_tone <= fifo_head;
         if (pop_req && fifo_empty && underflow_cnt != 8'hFF)
            underflow_cnt <= underflow_cnt + 8'd1;
         if (bus.sample_valid && !push_ok)
            overflow <= 1'b1;
      end
   end

   assign bus.sample_ready            = ~fifo_full;
   assign bus.left_channel_audio_out  = out_l;
   assign bus.right_channel_audio_out = out_r;
   assign fifo_level                  = 3'(fifo_lvl);

endmodule

// File: tb/tb_audio_mix_stage.sv
// Self-checking bench for audio_mix_stage: vector table plus hand-written multi-cycle sequences.
module tb_audio_mix_stage;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [2:0]  volume;
   logic        mute;
   logic        mic_enable;
   logic [2:0]  fifo_level;
   logic [7:0]  underflow_cnt;
   logic        overflow;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];

   always #5 CLOCK_50 = ~CLOCK_50;

   audio_mix_stage_if bus ();

   audio_mix_stage dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .bus           (bus.slave),
      .volume        (volume),
      .mute          (mute),
      .mic_enable    (mic_enable),
      .fifo_level    (fifo_level),
      .underflow_cnt (underflow_cnt),
      .overflow      (overflow)
   );

   typedef struct {
      logic [4:0]  smp;
      logic [2:0]  vol;
      logic        mte;
      logic        mic_en;
      logic [31:0] l_in;
      logic [31:0] r_in;
      logic [31:0] l_exp;
      logic [31:0] r_exp;
   } vec_t;

   vec_t vecs [7];

   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
      end
   endtask

   task automatic do_reset;
      reset                      = 1'b1;
      bus.sample_valid           = 1'b0;
      bus.sample_in              = 5'd0;
      bus.audio_in_available     = 1'b0;
      bus.audio_out_allowed      = 1'b0;
      bus.left_channel_audio_in  = 32'd0;
      bus.right_channel_audio_in = 32'd0;
      volume                     = 3'd0;
      mute                       = 1'b0;
      mic_enable                 = 1'b0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic push(input logic [4:0] s);
      bus.sample_valid = 1'b1;
      bus.sample_in    = s;
      tick;
      bus.sample_valid = 1'b0;
   endtask

   // Expected data enters the scoreboard at the decision cycle and leaves at the write strobe.
   task automatic frame(input string name, input logic [31:0] el, input logic [31:0] er);
      int waited;
      logic [31:0] ql, qr;
      exp_q.push_back(el);
      exp_q.push_back(er);
      bus.audio_in_available = 1'b1;
      bus.audio_out_allowed  = 1'b1;
      tick;
      bus.audio_in_available = 1'b0;
      bus.audio_out_allowed  = 1'b0;
      waited = 0;
      while (!bus.write_audio_out && waited < 8) begin
         tick;
         waited++;
      end
      ql = exp_q.pop_front();
      qr = exp_q.pop_front();
      if (!bus.write_audio_out) begin
         chk({name, " strobe timeout"}, 32'(bus.write_audio_out), 32'd1);
      end else begin
         chk({name, " read"},  32'(bus.read_audio_in), 32'd1);
         chk({name, " left"},  bus.left_channel_audio_out,  ql);
         chk({name, " right"}, bus.right_channel_audio_out, qr);
      end
      tick;
      tick;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int wr_cnt, bad, last;

      vecs[0] = '{5'd31, 3'd0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0078_0000, 32'h0078_0000};
      vecs[1] = '{5'd0,  3'd7, 1'b0, 1'b1, 32'h8000_0001, 32'h0000_0000, 32'h8000_0000, 32'hC000_0000};
      vecs[2] = '{5'd31, 3'd7, 1'b0, 1'b1, 32'h7FFF_FFF0, 32'h0000_0010, 32'h7FFF_FFFF, 32'h3C00_0010};
      vecs[3] = '{5'd16, 3'd3, 1'b0, 1'b1, 32'h0000_0011, 32'hFFFF_FFFB, 32'h0000_0011, 32'hFFFF_FFFB};
      vecs[4] = '{5'd1,  3'd2, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 32'h0000_0100, 32'h0000_0200};
      vecs[5] = '{5'd1,  3'd2, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0200, 32'hFE20_0000, 32'hFE20_0000};
      vecs[6] = '{5'd17, 3'd1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0010_0000, 32'h0010_0000};

      // Reset state
      do_reset;
      chk("rst write",     32'(bus.write_audio_out), 32'd0);
      chk("rst read",      32'(bus.read_audio_in), 32'd0);
      chk("rst left",      bus.left_channel_audio_out, 32'd0);
      chk("rst right",     bus.right_channel_audio_out, 32'd0);
      chk("rst ready",     32'(bus.sample_ready), 32'd1);
      chk("rst level",     32'(fifo_level), 32'd0);
      chk("rst underflow", 32'(underflow_cnt), 32'd0);
      chk("rst overflow",  32'(overflow), 32'd0);

      // Empty FIFO: mic passthrough, only frame 0 counts an underflow
      mic_enable                 = 1'b1;
      bus.left_channel_audio_in  = 32'h0000_1234;
      bus.right_channel_audio_in = 32'h0000_5678;
      for (int f = 0; f < 3; f++)
         frame($sformatf("empty f%0d", f), 32'h0000_1234, 32'h0000_5678);
      chk("empty underflow", 32'(underflow_cnt), 32'd1);

      // Vector table
      for (int i = 0; i < 7; i++) begin
         do_reset;
         volume                     = vecs[i].vol;
         mute                       = vecs[i].mte;
         mic_enable                 = vecs[i].mic_en;
         bus.left_channel_audio_in  = vecs[i].l_in;
         bus.right_channel_audio_in = vecs[i].r_in;
         push(vecs[i].smp);
         frame($sformatf("vec%0d", i), vecs[i].l_exp, vecs[i].r_exp);
      end

      // Tone held for 8 frames, next sample popped on frame 8
      do_reset;
      push(5'd31);
      push(5'd5);
      frame("hold f0", 32'h0078_0000, 32'h0078_0000);
      chk("hold level", 32'(fifo_level), 32'd1);
      for (int f = 1; f < 8; f++)
         frame($sformatf("hold f%0d", f), 32'h0078_0000, 32'h0078_0000);
      chk("hold level f7", 32'(fifo_level), 32'd1);
      frame("hold f8", 32'hFFA8_0000, 32'hFFA8_0000);
      chk("hold underflow", 32'(underflow_cnt), 32'd0);
      chk("hold level f8", 32'(fifo_level), 32'd0);

      // Overflow: fifth back-to-back push dropped
      do_reset;
      bus.sample_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.sample_in = 5'(i + 1);
         tick;
         if (i == 3) begin
            chk("ovf ready after 4", 32'(bus.sample_ready), 32'd0);
            chk("ovf flag after 4",  32'(overflow), 32'd0);
         end
      end
      bus.sample_valid = 1'b0;
      chk("ovf level", 32'(fifo_level), 32'd4);
      chk("ovf flag",  32'(overflow), 32'd1);
      tick;
      chk("ovf sticky", 32'(overflow), 32'd1);

      // Push and pop together on a full FIFO
      do_reset;
      for (int i = 0; i < 4; i++) push(5'd31);
      chk("pp full level", 32'(fifo_level), 32'd4);
      bus.sample_valid       = 1'b1;
      bus.sample_in          = 5'd2;
      bus.audio_in_available = 1'b1;
      bus.audio_out_allowed  = 1'b1;
      tick;
      bus.sample_valid       = 1'b0;
      bus.audio_in_available = 1'b0;
      bus.audio_out_allowed  = 1'b0;
      chk("pp write",    32'(bus.write_audio_out), 32'd1);
      chk("pp left",     bus.left_channel_audio_out, 32'h0078_0000);
      chk("pp level",    32'(fifo_level), 32'd4);
      chk("pp overflow", 32'(overflow), 32'd0);
      tick;
      tick;

      // Continuous availability: one frame every 3 cycles
      do_reset;
      bus.audio_in_available = 1'b1;
      bus.audio_out_allowed  = 1'b1;
      wr_cnt = 0;
      bad    = 0;
      last   = -1;
      for (int i = 0; i < 15; i++) begin
         tick;
         if (bus.write_audio_out !== bus.read_audio_in) bad++;
         if (bus.write_audio_out) begin
            if (last >= 0 && (i - last) != 3) bad++;
            last = i;
            wr_cnt++;
         end
      end
      bus.audio_in_available = 1'b0;
      bus.audio_out_allowed  = 1'b0;
      chk("b2b pulses",  32'(wr_cnt), 32'd5);
      chk("b2b spacing", 32'(bad), 32'd0);

      // Reset while WRITE is active
      do_reset;
      push(5'd31);
      push(5'd31);
      mic_enable                = 1'b1;
      bus.left_channel_audio_in = 32'h0000_1234;
      bus.audio_in_available    = 1'b1;
      bus.audio_out_allowed     = 1'b1;
      tick;
      bus.audio_in_available    = 1'b0;
      bus.audio_out_allowed     = 1'b0;
      chk("rw write before", 32'(bus.write_audio_out), 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rw write after", 32'(bus.write_audio_out), 32'd0);
      chk("rw read after",  32'(bus.read_audio_in), 32'd0);
      chk("rw left",        bus.left_channel_audio_out, 32'd0);
      chk("rw level",       32'(fifo_level), 32'd0);
      chk("rw ready",       32'(bus.sample_ready), 32'd1);

      // Mute with a full FIFO: mic only
      do_reset;
      for (int i = 0; i < 4; i++) push(5'd31);
      mute                       = 1'b1;
      mic_enable                 = 1'b1;
      bus.left_channel_audio_in  = 32'h0000_1234;
      bus.right_channel_audio_in = 32'h0000_ABCD;
      frame("mute full", 32'h0000_1234, 32'h0000_ABCD);
      chk("mute level", 32'(fifo_level), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
